rv_mc_core: RTL and testbench

Parametrised multicycle RV32I-subset core: one shared instruction/data memory port, one ALU, one FSM sequencing FETCH→DECODE→EXECUTE→WRITEBACK. It is the next generation of the team's multicycle top. It adds:
- data width as a parameter;
- a programmable reset vector;
- a stall-capable memory handshake (wait states);
- a per-instruction retire strobe;
- an illegal-instruction trap state.

It sits between the SoC memory/bus fabric and the debug observation ports.

---
 rtl/rv_mc_pkg.sv | 82 ++++++++
 rtl/rv_mc_alu.sv | 31 +++
 rtl/rv_mc_regfile.sv | 29 ++
 rtl/rv_mc_core.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_rv_mc_core.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_mc_pkg.sv
// rv_mc_pkg: shared types, encodings and decode helpers for the rv_mc_core
// multicycle RV32I-subset core. Imported by rv_mc_alu and rv_mc_core.
package rv_mc_pkg;

  // FSM states with fixed encodings; these are visible on state_out.
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_TRAP     = 4'd15
  } state_e;

  // Major opcodes of the supported base set.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operations.
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  // funct3 codes for ALU, memory and branch instructions.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // True for the funct3 values the ALU instructions support.
  function automatic logic alu_funct3_ok(input logic [2:0] funct3);
    return (funct3 == F3_ADD) || (funct3 == F3_SLT) ||
           (funct3 == F3_OR)  || (funct3 == F3_AND);
  endfunction

  // Maps an ALU instruction's funct3 (plus the SUB select bit) to an ALU op.
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLT:  return ALU_SLT;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // Branch comparisons reuse the ALU: equality via SUB/zero, ordering via SLT/SLTU.
  function automatic alu_op_e branch_alu_op(input logic [2:0] funct3);
    case (funct3)
      F3_BLT, F3_BGE:   return ALU_SLT;
      F3_BLTU, F3_BGEU: return ALU_SLTU;
      default:          return ALU_SUB;
    endcase
  endfunction

endpackage

// File: rtl/rv_mc_alu.sv
// rv_mc_alu: the core's single XLEN-wide ALU, shared by PC increment,
// address generation, arithmetic and branch comparison.
module rv_mc_alu
  import rv_mc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  // Combinational result; comparisons return 0/1 in bit 0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      default:  y = '0;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/rv_mc_regfile.sv
// rv_mc_regfile: 32 x XLEN register file, two asynchronous read ports and one
// synchronous write port. x0 always reads zero and ignores writes.
module rv_mc_regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [32];

  // Write port; the x0 entry is never written.
  // NOTE: the storage array has no reset so it maps onto plain RAM/flops without a reset network; software must not rely on register contents after reset.
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/rv_mc_core.sv
// rv_mc_core: parametrised multicycle RV32I-subset core with one shared
// instruction/data memory port (stall-capable), one ALU and a
// FETCH/DECODE/EXECUTE/WRITEBACK FSM. Illegal instructions park the core in TRAP.
// Optional feature: define BRANCH_EXT_EN to make BNE/BLT/BGE/BLTU/BGEU legal.
module rv_mc_core
  import rv_mc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [3:0]      state_out,
  output logic            retire,
  output logic            illegal
);

  state_e state, state_next;

  logic [XLEN-1:0] pc, old_pc, mdr, reg_a, reg_b, alu_out;
  logic [31:0]     ir;

  // Instruction fields.
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  // Sign-extended immediates.
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // Register file.
  logic            rf_we, rf_we_int;
  logic [XLEN-1:0] rf_wdata, rs1_data, rs2_data;

  rv_mc_regfile #(.XLEN(XLEN)) u_regfile (
    .clk    (clk),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // ALU.
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  alu_op_e         alu_op;
  logic            alu_zero;

  rv_mc_alu #(.XLEN(XLEN)) u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Legality check of the instruction held in IR.
  logic legal;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: legal = (funct3 == F3_WORD);
      OP_RTYPE:          legal = ((funct7 == F7_BASE) && alu_funct3_ok(funct3)) ||
                                 ((funct7 == F7_ALT) && (funct3 == F3_ADD));
      OP_ITYPE:          legal = alu_funct3_ok(funct3);
`ifdef BRANCH_EXT_EN
      OP_BRANCH:         legal = (funct3 != 3'b010) && (funct3 != 3'b011);
`else
      OP_BRANCH:         legal = (funct3 == F3_BEQ);
`endif
      OP_JAL:            legal = 1'b1;
      default:           legal = 1'b0;
    endcase
  end

  // ALU operand and operation select, one use per state.
  always_comb begin
    alu_a  = pc;
    alu_b  = XLEN'(4);
    alu_op = ALU_ADD;
    case (state)
      ST_DECODE: begin
        alu_a = old_pc;
        alu_b = (opcode == OP_JAL) ? imm_j : imm_b;
      end
      ST_MEMADR: begin
        alu_a = reg_a;
        alu_b = (opcode == OP_STORE) ? imm_s : imm_i;
      end
      ST_EXECR: begin
        alu_a  = reg_a;
        alu_b  = reg_b;
        alu_op = alu_op_decode(funct3, funct7[5]);
      end
      ST_EXECI: begin
        alu_a  = reg_a;
        alu_b  = imm_i;
        alu_op = alu_op_decode(funct3, 1'b0);
      end
      ST_BRANCH: begin
        alu_a  = reg_a;
        alu_b  = reg_b;
        alu_op = branch_alu_op(funct3);
      end
      ST_JAL: begin
        alu_a = old_pc;
        alu_b = XLEN'(4);
      end
      default: ;
    endcase
  end

  // Branch decision from the ALU comparison result.
  logic branch_taken;

  always_comb begin
    branch_taken = 1'b0;
`ifdef BRANCH_EXT_EN
    case (funct3)
      F3_BEQ:           branch_taken = alu_zero;
      F3_BNE:           branch_taken = !alu_zero;
      F3_BLT, F3_BLTU:  branch_taken = alu_y[0];
      F3_BGE, F3_BGEU:  branch_taken = !alu_y[0];
      default:          branch_taken = 1'b0;
    endcase
`else
    branch_taken = alu_zero;
`endif
  end

  // Register-file write data source.
  always_comb begin
    case (state)
      ST_MEMWB: rf_wdata = mdr;
      ST_JAL:   rf_wdata = alu_y;
      default:  rf_wdata = alu_out;
    endcase
  end

  // FSM next-state logic and control outputs.
  logic req_int, we_int, retire_int;

  always_comb begin
    state_next = state;
    req_int    = 1'b0;
    we_int     = 1'b0;
    retire_int = 1'b0;
    rf_we_int  = 1'b0;
    mem_addr   = pc;
    case (state)
      ST_FETCH: begin
        req_int = 1'b1;
        if (mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (!legal) begin
          state_next = ST_TRAP;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_next = ST_MEMADR;
            OP_RTYPE:          state_next = ST_EXECR;
            OP_ITYPE:          state_next = ST_EXECI;
            OP_BRANCH:         state_next = ST_BRANCH;
            OP_JAL:            state_next = ST_JAL;
            default:           state_next = ST_TRAP;
          endcase
        end
      end
      ST_MEMADR:
        state_next = (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD: begin
        req_int  = 1'b1;
        mem_addr = alu_out;
        if (mem_ready) state_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        rf_we_int  = 1'b1;
        retire_int = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEMWRITE: begin
        req_int  = 1'b1;
        we_int   = 1'b1;
        mem_addr = alu_out;
        if (mem_ready) begin
          retire_int = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_EXECR, ST_EXECI:
        state_next = ST_ALUWB;
      ST_ALUWB: begin
        rf_we_int  = 1'b1;
        retire_int = 1'b1;
        state_next = ST_FETCH;
      end
      ST_BRANCH: begin
        retire_int = 1'b1;
        state_next = ST_FETCH;
      end
      ST_JAL: begin
        rf_we_int  = 1'b1;
        retire_int = 1'b1;
        state_next = ST_FETCH;
      end
      ST_TRAP:
        state_next = ST_TRAP;
      default:
        state_next = ST_TRAP;
    endcase
  end

  // Reset drops the request and blocks regfile writes in the same cycle.
  assign mem_req   = req_int & rst;
  assign mem_we    = we_int & rst;
  assign retire    = retire_int & rst;
  assign rf_we     = rf_we_int & rst;
  assign mem_wdata = reg_b;
  assign pc_out    = pc;
  assign state_out = state;
  assign illegal   = (state == ST_TRAP);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values regardless of block ordering.
    if (!rst) state <= ST_FETCH;
    else      state <= state_next;
  end

  // Datapath registers; memory-facing updates only on mem_ready so stalls hold everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      old_pc  <= '0;
      ir      <= '0;
      mdr     <= '0;
      reg_a   <= '0;
      reg_b   <= '0;
      alu_out <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            ir     <= mem_rdata[31:0];
            old_pc <= pc;
            pc     <= alu_y;
          end
        end
        ST_DECODE: begin
          reg_a   <= rs1_data;
          reg_b   <= rs2_data;
          alu_out <= alu_y;
        end
        ST_MEMADR, ST_EXECR, ST_EXECI:
          alu_out <= alu_y;
        ST_MEMREAD:
          if (mem_ready) mdr <= mem_rdata;
        ST_BRANCH:
          if (branch_taken) pc <= alu_out;
        ST_JAL:
          pc <= alu_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mc_core.sv
// tb_rv_mc_core: directed self-checking bench for rv_mc_core (RESET_PC=0x100).
// A small program is preloaded; register results are observed through stores.
// BRANCH_EXT_EN selects the extended-branch expectations.
module tb_rv_mc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, retire, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, trap_pc;
  logic [3:0]  state_out;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [256];
  int wait_cfg = 0;
  int wait_cnt = 0;

  rv_mc_core #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .state_out (state_out),
    .retire    (retire),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Memory responder: wait_cfg stall cycles before each access completes.
  assign mem_ready = mem_req && (wait_cnt >= wait_cfg);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from its FETCH cycle to retire, checking latency and,
  // for stores, the memory write presented in the retire cycle.
  task automatic run_core(input string tag, input int exp_cyc, input bit st,
                          input logic [31:0] st_addr, input logic [31:0] st_data);
    int n;
    n = 1;
    while (!retire && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_cycles"}, n, exp_cyc);
    if (st) begin
      check({tag, "_we"}, {31'd0, mem_we}, 32'd1);
      check({tag, "_addr"}, mem_addr, st_addr);
      check({tag, "_wdata"}, mem_wdata, st_data);
      if (mem_req && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    end
    tick();
  endtask

  task automatic run(input string tag, input int exp_cyc);
    run_core(tag, exp_cyc, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic run_sw(input string tag, input logic [31:0] addr, input logic [31:0] data);
    run_core(tag, 4, 1'b1, addr, data);
  endtask

  // Instruction encoders.
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[9:2]] = word;
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_007F;
    put(32'h024, 32'hDEAD_BEEF);

    put(32'h100, enc_i(12'd5,    5'd0, 3'b000, 5'd1, 7'b0010011)); // addi x1,x0,5
    put(32'h104, enc_s(12'd0,    5'd1, 5'd0));                     // sw x1,0(x0)
    put(32'h108, enc_i(12'hA5,   5'd0, 3'b000, 5'd1, 7'b0010011)); // addi x1,x0,0xA5
    put(32'h10C, enc_s(12'd0,    5'd1, 5'd0));                     // sw x1,0(x0)
    put(32'h110, enc_i(12'd0,    5'd0, 3'b010, 5'd6, 7'b0000011)); // lw x6,0(x0)
    put(32'h114, enc_s(12'd4,    5'd6, 5'd0));                     // sw x6,4(x0)
    put(32'h118, enc_i(12'h20,   5'd0, 3'b000, 5'd2, 7'b0010011)); // addi x2,x0,0x20
    put(32'h11C, enc_i(12'd4,    5'd2, 3'b010, 5'd3, 7'b0000011)); // lw x3,4(x2)
    put(32'h120, enc_s(12'd0,    5'd3, 5'd0));                     // sw x3,0(x0)
    put(32'h124, enc_b(13'd8,    5'd6, 5'd1, 3'b000));             // beq x1,x6,+8
    put(32'h12C, enc_b(13'd8,    5'd2, 5'd1, 3'b000));             // beq x1,x2,+8
    put(32'h130, enc_j(21'd16,   5'd5));                           // jal x5,+16
    put(32'h140, enc_i(12'd7,    5'd0, 3'b000, 5'd0, 7'b0010011)); // addi x0,x0,7
    put(32'h144, enc_s(12'd0,    5'd5, 5'd0));                     // sw x5,0(x0)
    put(32'h148, enc_s(12'd0,    5'd0, 5'd0));                     // sw x0,0(x0)
    put(32'h14C, enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd8));          // sub x8,x2,x1
    put(32'h150, enc_r(7'h00, 5'd1, 5'd8, 3'b010, 5'd9));          // slt x9,x8,x1
    put(32'h154, enc_i(12'hFFF,  5'd1, 3'b010, 5'd10, 7'b0010011));// slti x10,x1,-1
    put(32'h158, enc_r(7'h00, 5'd2, 5'd9, 3'b110, 5'd11));         // or x11,x9,x2
    put(32'h15C, enc_i(12'hFF,   5'd3, 3'b111, 5'd12, 7'b0010011));// andi x12,x3,0xFF
    put(32'h160, enc_s(12'd0,    5'd8,  5'd0));                    // sw x8
    put(32'h164, enc_s(12'd0,    5'd9,  5'd0));                    // sw x9
    put(32'h168, enc_s(12'd0,    5'd10, 5'd0));                    // sw x10
    put(32'h16C, enc_s(12'd0,    5'd11, 5'd0));                    // sw x11
    put(32'h170, enc_s(12'd0,    5'd12, 5'd0));                    // sw x12
    put(32'h174, enc_b(13'd8,    5'd2, 5'd1, 3'b001));             // bne x1,x2,+8

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",     {31'd0, mem_req}, 32'd0);
    check("rst_state",   {28'd0, state_out}, 32'd0);
    check("rst_pc",      pc_out, 32'h100);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_retire",  {31'd0, retire}, 32'd0);
    rst = 1'b1;
    #1;
    check("first_req",  {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h100);

    // ALU immediate, stores, load round trip.
    run("addi_x1_5", 4);
    check("addi_pc", pc_out, 32'h104);
    run_sw("sw_x1_5", 32'h0, 32'h5);
    run("addi_x1_a5", 4);
    run_sw("sw_x1_a5", 32'h0, 32'hA5);
    run("lw_x6", 5);
    run_sw("sw_x6", 32'h4, 32'hA5);
    run("addi_x2", 4);

    // LW with three wait states on the data access.
    tick();
    tick();
    wait_cfg = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lw_wait_addr",  mem_addr, 32'h24);
      check("lw_wait_state", {28'd0, state_out}, 32'd3);
      check("lw_wait_we",    {31'd0, mem_we}, 32'd0);
    end
    tick();
    check("lw_wait_retire", {31'd0, retire}, 32'd1);
    check("lw_wait_memwb",  {28'd0, state_out}, 32'd4);
    wait_cfg = 0;
    tick();
    run_sw("sw_x3", 32'h0, 32'hDEAD_BEEF);

    // Branches and jump.
    run("beq_taken", 3);
    check("beq_taken_pc", pc_out, 32'h12C);
    run("beq_not_taken", 3);
    check("beq_nt_pc", pc_out, 32'h130);
    run("jal", 3);
    check("jal_pc", pc_out, 32'h140);
    run("addi_x0", 4);
    run_sw("sw_x5", 32'h0, 32'h134);
    run_sw("sw_x0", 32'h0, 32'h0);

    // R-type and I-type arithmetic.
    run("sub", 4);
    run("slt", 4);
    run("slti", 4);
    run("or", 4);
    run("andi", 4);
    run_sw("sw_sub",  32'h0, 32'hFFFF_FF7B);
    run_sw("sw_slt",  32'h0, 32'h1);
    run_sw("sw_slti", 32'h0, 32'h0);
    run_sw("sw_or",   32'h0, 32'h21);
    run_sw("sw_andi", 32'h0, 32'hEF);

    // Trap on an illegal instruction.
`ifdef BRANCH_EXT_EN
    run("bne_taken", 3);
    check("bne_pc", pc_out, 32'h17C);
    trap_pc = 32'h180;
`else
    trap_pc = 32'h178;
`endif
    tick();
    tick();
    check("trap_illegal", {31'd0, illegal}, 32'd1);
    check("trap_state",   {28'd0, state_out}, 32'd15);
    check("trap_pc",      pc_out, trap_pc);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("trap_req",    {31'd0, mem_req}, 32'd0);
      check("trap_retire", {31'd0, retire}, 32'd0);
      check("trap_hold",   {28'd0, state_out}, 32'd15);
    end

    // Reset leaves TRAP; reset during a stalled fetch drops the request.
    wait_cfg = 2;
    rst = 1'b0;
    #1;
    check("rst2_state",   {28'd0, state_out}, 32'd0);
    check("rst2_illegal", {31'd0, illegal}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("stall_req",  {31'd0, mem_req}, 32'd1);
    check("stall_addr", mem_addr, 32'h100);
    tick();
    check("stall_state", {28'd0, state_out}, 32'd0);
    check("stall_addr2", mem_addr, 32'h100);
    rst = 1'b0;
    #1;
    check("midrst_req",   {31'd0, mem_req}, 32'd0);
    check("midrst_state", {28'd0, state_out}, 32'd0);
    check("midrst_pc",    pc_out, 32'h100);
    tick();
    wait_cfg = 0;
    rst = 1'b1;
    #1;
    run("addi_after_rst", 4);
    check("addi_after_rst_pc", pc_out, 32'h104);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
